// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Round-robin four-lane signal sequencer: GREEN -> YELLOW -> ALL_RED -> next lane.
//   Green time grows with the served lane's vehicle count (saturated), and lanes
//   with no vehicles are skipped. All timing advances only on the tick strobe.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous, active-low reset
//   tick         in   1  one-cycle timebase strobe
//   count1..4    in   4  vehicle counts for lanes 0..3
//   green        out  4  one-hot green lamp (bit n = lane n)
//   yellow       out  4  one-hot yellow lamp
//   red          out  4  red lamp, always ~(green|yellow)
//   active_lane  out  2  lane currently (or last) served
//   remaining    out  8  ticks left in the current phase
//   phase_done   out  1  one-cycle pulse following every state change
//   ped_req      in   1  pedestrian request      (PED_REQ_EN only)
//   walk         out  1  pedestrian walk lamp    (PED_REQ_EN only)
//
// Build option
//   PED_REQ_EN : adds the pedestrian all-red walk phase after YELLOW.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN     = 4,
  parameter int GREEN_PER_CAR = 2,
  parameter int MAX_GREEN     = 30,
  parameter int YELLOW_TIME   = 3,
  parameter int ALLRED_TIME   = 1,
  parameter int PED_TIME      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] count1,
  input  logic [3:0] count2,
  input  logic [3:0] count3,
  input  logic [3:0] count4,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] active_lane,
  output logic [7:0] remaining,
`ifdef PED_REQ_EN
  output logic       phase_done,
  input  logic       ped_req,
  output logic       walk
`else
  output logic       phase_done
`endif
);

`ifdef PED_REQ_EN
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_PED} state_t;
`else
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

  state_t     state;
  logic [3:0] cnt [4];
  logic [1:0] sel_lane;
  logic [3:0] sel_cnt;
  logic [1:0] cand;
  logic       found;
  logic       expire;

  assign cnt[0] = count1;
  assign cnt[1] = count2;
  assign cnt[2] = count3;
  assign cnt[3] = count4;

  // The current phase ends on a tick that finds one tick left.
  assign expire = tick && (remaining == 8'd1);

  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Green time in 16 bits so a large count cannot wrap before the ceiling is applied.
  function automatic logic [7:0] green_dur(input logic [3:0] c);
    logic [15:0] d;
    d = 16'(MIN_GREEN) + 16'(c) * 16'(GREEN_PER_CAR);
    if (d > 16'(MAX_GREEN)) return 8'(MAX_GREEN);
    return d[7:0];
  endfunction

  // Scan the three following lanes first and the current lane last (k=4 wraps
  // back to active_lane); with no traffic anywhere fall back to the next lane.
  always_comb begin
    sel_lane = active_lane + 2'd1;
    sel_cnt  = 4'd0;
    found    = 1'b0;
    cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = active_lane + 2'(k);
      if (!found && (cnt[cand] != 4'd0)) begin
        found    = 1'b1;
        sel_lane = cand;
        sel_cnt  = cnt[cand];
      end
    end
  end

`ifdef PED_REQ_EN
  logic ped_pend;
  logic ped_entry;

  assign ped_entry = expire && (state == S_YELLOW) && ped_pend;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_ALLRED;
      active_lane <= 2'd3;
      remaining   <= 8'(ALLRED_TIME);
      green       <= 4'h0;
      yellow      <= 4'h0;
      red         <= 4'hF;
      phase_done  <= 1'b0;
`ifdef PED_REQ_EN
      walk        <= 1'b0;
      ped_pend    <= 1'b0;
`endif
    end else begin
      phase_done <= expire;
`ifdef PED_REQ_EN
      // A request in the PED entry cycle re-arms the flag for the next visit.
      ped_pend <= ped_req | (ped_pend & ~ped_entry);
`endif
      if (tick && !expire) begin
        remaining <= remaining - 8'd1;
      end else if (expire) begin
        case (state)
          S_GREEN: begin
            state     <= S_YELLOW;
            remaining <= 8'(YELLOW_TIME);
            green     <= 4'h0;
            yellow    <= lane_onehot(active_lane);
            red       <= ~lane_onehot(active_lane);
          end
          S_YELLOW: begin
            yellow <= 4'h0;
            red    <= 4'hF;
`ifdef PED_REQ_EN
            if (ped_pend) begin
              state     <= S_PED;
              remaining <= 8'(PED_TIME);
              walk      <= 1'b1;
            end else begin
              state     <= S_ALLRED;
              remaining <= 8'(ALLRED_TIME);
            end
`else
            state     <= S_ALLRED;
            remaining <= 8'(ALLRED_TIME);
`endif
          end
          S_ALLRED: begin
            state       <= S_GREEN;
            active_lane <= sel_lane;
            remaining   <= green_dur(sel_cnt);
            green       <= lane_onehot(sel_lane);
            yellow      <= 4'h0;
            red         <= ~lane_onehot(sel_lane);
          end
`ifdef PED_REQ_EN
          S_PED: begin
            state     <= S_ALLRED;
            remaining <= 8'(ALLRED_TIME);
            walk      <= 1'b0;
          end
`endif
          default: begin
            state     <= S_ALLRED;
            remaining <= 8'(ALLRED_TIME);
            green     <= 4'h0;
            yellow    <= 4'h0;
            red       <= 4'hF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler
//   Self-checking bench for traffic_phase_scheduler. A phase-level reference
//   model (current phase, lane and ticks left) is advanced once per clock and
//   its predicted lamp/timer outputs are compared after every edge, alongside
//   fixed expectations for the directed traffic scenarios.
//   PED_REQ_EN, when defined, also enables the pedestrian scenario.
module tb_traffic_phase_scheduler;
  localparam int MIN_GREEN     = 4;
  localparam int GREEN_PER_CAR = 2;
  localparam int MAX_GREEN     = 30;
  localparam int YELLOW_TIME   = 3;
  localparam int ALLRED_TIME   = 1;
  localparam int PED_TIME      = 8;
`ifdef PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  localparam int PH_GREEN = 0, PH_YELLOW = 1, PH_ALLRED = 2, PH_PED = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] cnt [4];
  logic       ped_req;
  logic [3:0] green, yellow, red;
  logic [1:0] active_lane;
  logic [7:0] remaining;
  logic       phase_done;
  logic       walk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int m_ph, m_lane, m_rem;
  bit m_done, m_pend;

  traffic_phase_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick),
    .count1(cnt[0]), .count2(cnt[1]), .count3(cnt[2]), .count4(cnt[3]),
    .green(green), .yellow(yellow), .red(red),
    .active_lane(active_lane), .remaining(remaining),
`ifdef PED_REQ_EN
    .phase_done(phase_done), .ped_req(ped_req), .walk(walk)
`else
    .phase_done(phase_done)
`endif
  );

`ifndef PED_REQ_EN
  assign walk = 1'b0;
`endif

  always #5 clk = ~clk;

  wire [23:0] obs = {walk, green, yellow, red, active_lane, remaining, phase_done};

  task automatic model_reset();
    m_ph = PH_ALLRED; m_lane = 3; m_rem = ALLRED_TIME; m_done = 1'b0; m_pend = 1'b0;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_clock();
    bit adv, entry, found;
    int nl, c, l, d;
    adv   = tick && (m_rem == 1);
    entry = adv && (m_ph == PH_YELLOW) && m_pend;
    m_done = adv;
    if (PED) m_pend = (m_pend && !entry) || ped_req;
    if (tick && !adv) m_rem = m_rem - 1;
    else if (adv) begin
      case (m_ph)
        PH_GREEN:  begin m_ph = PH_YELLOW; m_rem = YELLOW_TIME; end
        PH_YELLOW: if (entry) begin m_ph = PH_PED; m_rem = PED_TIME; end
                   else begin m_ph = PH_ALLRED; m_rem = ALLRED_TIME; end
        PH_PED:    begin m_ph = PH_ALLRED; m_rem = ALLRED_TIME; end
        default: begin
          nl = (m_lane + 1) % 4; c = 0; found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            l = (m_lane + k) % 4;
            if (!found && cnt[l] != 0) begin found = 1'b1; nl = l; c = cnt[l]; end
          end
          d = MIN_GREEN + c * GREEN_PER_CAR;
          m_lane = nl;
          m_rem  = (d > MAX_GREEN) ? MAX_GREEN : d;
          m_ph   = PH_GREEN;
        end
      endcase
    end
  endtask

  function automatic logic [23:0] exp_vec();
    logic [3:0] g, y;
    g = (m_ph == PH_GREEN)  ? (4'b0001 << m_lane) : 4'h0;
    y = (m_ph == PH_YELLOW) ? (4'b0001 << m_lane) : 4'h0;
    return {(m_ph == PH_PED), g, y, ~(g | y), 2'(m_lane), 8'(m_rem), m_done};
  endfunction

  task automatic set_counts(input int a, input int b, input int c, input int d);
    cnt[0] = 4'(a); cnt[1] = 4'(b); cnt[2] = 4'(c); cnt[3] = 4'(d);
  endtask

  // Leaves time at posedge+1 with reset released and the model reset.
  task automatic apply_reset();
    rst = 1'b0; tick = 1'b0; ped_req = 1'b0;
    #2;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] rv;
    rv = {1'b0, 4'h0, 4'h0, 4'hF, 2'd3, 8'(ALLRED_TIME), 1'b0};
    tick = 1'b1; ped_req = 1'b0; set_counts(9, 7, 5, 3);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    compared++;
    if (obs !== rv) begin
      mismatched++;
      $display("FAIL reset_async: got %h expected %h", obs, rv);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++;
      if (obs !== rv) begin
        mismatched++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, rv);
      end
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_all_zero();
    int first0, period;
    first0 = -1; period = -1;
    apply_reset();
    set_counts(0, 0, 0, 0); tick = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); model_clock(); #1;
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL all_zero cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (phase_done && green == 4'b0001) begin
        if (first0 < 0) first0 = i;
        else if (period < 0) period = i - first0;
      end
    end
    compared++;
    if (first0 !== 0 || period !== 32) begin
      mismatched++;
      $display("FAIL all_zero_period: first lane0 green at %0d period %0d, expected 0 and 32", first0, period);
    end
  endtask

  task automatic test_single_lane();
    int greens;
    greens = 0;
    apply_reset();
    set_counts(5, 0, 0, 0); tick = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); model_clock(); #1;
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL single_lane cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (phase_done && green != 4'h0) begin
        greens++;
        compared++;
        if ({green, remaining} !== {4'b0001, 8'd14}) begin
          mismatched++;
          $display("FAIL single_lane_entry: green %b remaining %0d, expected 0001 and 14", green, remaining);
        end
      end
    end
    compared++;
    if (greens !== 4) begin
      mismatched++;
      $display("FAIL single_lane_count: %0d green entries, expected 4", greens);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    set_counts(0, 0, 15, 0); tick = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); model_clock(); #1;
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL saturate cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i == 0) begin
        compared++;
        if ({green, remaining} !== {4'b0100, 8'd30}) begin
          mismatched++;
          $display("FAIL saturate_entry: green %b remaining %0d, expected 0100 and 30", green, remaining);
        end
      end
    end
  endtask

  task automatic test_skip();
    int n;
    int lanes [3];
    int durs [3];
    n = 0;
    apply_reset();
    set_counts(0, 2, 0, 1); tick = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); model_clock(); #1;
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL skip cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (phase_done && green != 4'h0 && n < 3) begin
        lanes[n] = int'(active_lane); durs[n] = int'(remaining); n++;
      end
    end
    compared++;
    if (n !== 3 || lanes[0] !== 1 || durs[0] !== 8 || lanes[1] !== 3 || durs[1] !== 6
        || lanes[2] !== 1 || durs[2] !== 8) begin
      mismatched++;
      $display("FAIL skip_order: %0d entries, lanes %0d/%0d/%0d greens %0d/%0d/%0d, expected 1/3/1 and 8/6/8",
               n, lanes[0], lanes[1], lanes[2], durs[0], durs[1], durs[2]);
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] rv;
    rv = {1'b0, 4'h0, 4'h0, 4'hF, 2'd3, 8'(ALLRED_TIME), 1'b0};
    apply_reset();
    set_counts($urandom_range(15, 1), $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0));
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); model_clock(); #1;
      cnt[1] = 4'($urandom_range(15, 0));
    end
    cnt[0] = 4'($urandom_range(15, 1));
    #2 rst = 1'b0;
    #1;
    compared++;
    if (obs !== rv) begin
      mismatched++;
      $display("FAIL mid_reset_values: got %h expected %h", obs, rv);
    end
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); model_clock(); #1;
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL mid_reset cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i == 0) begin
        compared++;
        if (green !== 4'b0001) begin
          mismatched++;
          $display("FAIL mid_reset_first_lane: green %b expected 0001", green);
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    set_counts(0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      tick = 1'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) cnt[$urandom_range(3, 0)] = 4'($urandom_range(15, 0));
      if ($urandom_range(5, 0) == 0) cnt[$urandom_range(3, 0)] = 4'h0;
      ped_req = PED && ($urandom_range(19, 0) == 0);
      @(posedge clk); model_clock(); #1;
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    ped_req = 1'b0;
  endtask

`ifdef PED_REQ_EN
  task automatic test_ped();
    int walk_cycles;
    bit seen;
    walk_cycles = 0; seen = 1'b0;
    apply_reset();
    set_counts(0, 0, 0, 0); tick = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ped_req = (i == 2);
      @(posedge clk); model_clock(); #1;
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL ped cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (walk) walk_cycles++;
      if (walk && !seen) begin
        seen = 1'b1;
        compared++;
        if ({red, remaining, i} !== {4'hF, 8'd8, 32'sd7}) begin
          mismatched++;
          $display("FAIL ped_entry: red %h remaining %0d at cycle %0d, expected F, 8, 7", red, remaining, i);
        end
      end
    end
    ped_req = 1'b0;
    compared++;
    if (walk_cycles !== 8) begin
      mismatched++;
      $display("FAIL ped_walk_len: walk high %0d cycles, expected 8", walk_cycles);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; tick = 1'b0; ped_req = 1'b0;
    set_counts(0, 0, 0, 0);
    model_reset();
    test_reset();
    test_all_zero();
    test_single_lane();
    test_saturate();
    test_skip();
    test_mid_reset();
`ifdef PED_REQ_EN
    test_ped();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
